// File: rtl/reservoir_pkg.sv
// Shared types and helpers for the reservoir level controller.
package reservoir_pkg;

  // Widest sensor stack the helper functions can handle.
  localparam int unsigned MAX_SENSORS     = 32;
  localparam int unsigned NUM_SENSORS_DEF = 3;

  typedef logic [$clog2(NUM_SENSORS_DEF+1)-1:0] level_t;

  // Direction of the last level move; it selects the supplemental valve hysteresis.
  typedef enum logic {
    DIR_RISING  = 1'b0,
    DIR_FALLING = 1'b1
  } dir_e;

  // True when the low n bits of vec form 0...01...1 (no set bit above a clear one).
  function automatic logic is_thermometer(input logic [MAX_SENSORS-1:0] vec,
                                          input int unsigned n);
    logic ok;
    ok = 1'b1;
    for (int unsigned i = 1; i < MAX_SENSORS; i++) begin
      if (i < n && vec[i] && !vec[i-1]) ok = 1'b0;
    end
    return ok;
  endfunction

  // Nominal valve pattern: valve i open while i < n - lvl.
  function automatic logic [MAX_SENSORS-1:0] fr_decode(input int unsigned lvl,
                                                       input int unsigned n);
    logic [MAX_SENSORS-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < MAX_SENSORS; i++) begin
      v[i] = (i + lvl < n);
    end
    return v;
  endfunction

endpackage

// File: rtl/reservoir_level_ctrl_if.sv
// Sensor/valve bundle between the sensor stage, this controller and the valve driver.
interface reservoir_level_ctrl_if #(
  parameter int unsigned NUM_SENSORS = 3
) ();
  localparam int unsigned LVL_W = $clog2(NUM_SENSORS+1);

  logic [NUM_SENSORS-1:0] s;
  logic                   clr_fault;
  logic [NUM_SENSORS-1:0] fr;
  logic                   dfr;
  logic [LVL_W-1:0]       level;
  logic                   fault;
  logic                   fault_sticky;

  modport master (
    output s, clr_fault,
    input  fr, dfr, level, fault, fault_sticky
  );

  modport slave (
    input  s, clr_fault,
    output fr, dfr, level, fault, fault_sticky
  );
endinterface

// File: rtl/sensor_debounce.sv
// Single-bit sensor filter: output follows the input only after a run of
// DEBOUNCE_CYCLES consecutive samples that disagree with it.
module sensor_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_d,
  output logic o_q
);
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES+1);

  logic             r_q;
  logic [CNT_W-1:0] r_cnt;

  // Count disagreeing samples; any agreeing sample restarts the run.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_q   <= 1'b0;
      r_cnt <= '0;
    end else if (i_d == r_q) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES-1)) begin
      r_q   <= i_d;
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_q = r_q;
endmodule

// File: rtl/reservoir_level_ctrl.sv
// Reservoir flow controller: tracks water level from a stack of sensors (one
// step per cycle), drives the nominal and supplemental valves and flags
// non-thermometer sensor codes.
// Optional input filtering: define RESERVOIR_DEBOUNCE_EN.
module reservoir_level_ctrl
  import reservoir_pkg::*;
#(
  parameter int unsigned NUM_SENSORS     = 3,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input logic                   clk,
  input logic                   reset_n,
  reservoir_level_ctrl_if.slave bus
);
  localparam int unsigned LVL_W    = $clog2(NUM_SENSORS+1);
  localparam int unsigned SV_EXT_W = 1 << LVL_W;

  // Reject unusable parameterisations at elaboration.
  if (NUM_SENSORS < 2 || NUM_SENSORS > MAX_SENSORS || DEBOUNCE_CYCLES < 1) begin : g_bad_param
    $error("reservoir_level_ctrl: illegal NUM_SENSORS/DEBOUNCE_CYCLES");
  end

  logic [NUM_SENSORS-1:0] w_sv;
  logic [SV_EXT_W-1:0]    w_sv_ext;

`ifdef RESERVOIR_DEBOUNCE_EN
  // One filter per sensor bit.
  for (genvar g = 0; g < NUM_SENSORS; g++) begin : g_deb
    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk     (clk),
      .reset_n (reset_n),
      .i_d     (bus.s[g]),
      .o_q     (w_sv[g])
    );
  end
`else
  assign w_sv = bus.s;
`endif

  // Zero-pad so the level can index the sensor vector at its natural width.
  assign w_sv_ext = SV_EXT_W'(w_sv);

  logic [LVL_W-1:0]       r_level,   w_level_nxt;
  dir_e                   r_dir,     w_dir_nxt;
  logic [NUM_SENSORS-1:0] r_fr,      w_fr_nxt;
  logic                   r_dfr,     w_dfr_nxt;
  logic                   r_fault,   w_fault_nxt;
  logic                   r_sticky,  w_sticky_nxt;

  // State and registered outputs; reset leaves all valves open.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_level  <= '0;
      r_dir    <= DIR_FALLING;
      r_fr     <= '1;
      r_dfr    <= 1'b1;
      r_fault  <= 1'b0;
      r_sticky <= 1'b0;
    end else begin
      r_level  <= w_level_nxt;
      r_dir    <= w_dir_nxt;
      r_fr     <= w_fr_nxt;
      r_dfr    <= w_dfr_nxt;
      r_fault  <= w_fault_nxt;
      r_sticky <= w_sticky_nxt;
    end
  end

  // Single-step level move, valve decode of the next state, fault flags.
  always_comb begin
    w_level_nxt = r_level;
    w_dir_nxt   = r_dir;
    if (r_level < LVL_W'(NUM_SENSORS) && w_sv_ext[r_level]) begin
      w_level_nxt = r_level + LVL_W'(1);
      w_dir_nxt   = DIR_RISING;
    end else if (r_level != '0 && !w_sv_ext[r_level - LVL_W'(1)]) begin
      w_level_nxt = r_level - LVL_W'(1);
      w_dir_nxt   = DIR_FALLING;
    end
    w_fr_nxt     = NUM_SENSORS'(fr_decode(32'(w_level_nxt), NUM_SENSORS));
    w_dfr_nxt    = (w_level_nxt == '0) ||
                   (w_dir_nxt == DIR_FALLING && w_level_nxt < LVL_W'(NUM_SENSORS));
    w_fault_nxt  = !is_thermometer(MAX_SENSORS'(w_sv), NUM_SENSORS);
    w_sticky_nxt = (r_sticky && !bus.clr_fault) || w_fault_nxt;
  end

  assign bus.fr           = r_fr;
  assign bus.dfr          = r_dfr;
  assign bus.level        = r_level;
  assign bus.fault        = r_fault;
  assign bus.fault_sticky = r_sticky;
endmodule

// File: tb/tb_reservoir_level_ctrl.sv
// Directed + random bench for reservoir_level_ctrl (N=3) with an expected-result queue.
module tb_reservoir_level_ctrl;
  import reservoir_pkg::*;

  localparam int unsigned N = 3;

  typedef struct packed {
    logic [2:0] fr;
    logic       dfr;
    level_t     level;
    logic       fault;
    logic       sticky;
  } exp_t;

  logic clk;
  logic reset_n;
  reservoir_level_ctrl_if #(.NUM_SENSORS(N)) bus ();

  reservoir_level_ctrl #(.NUM_SENSORS(N), .DEBOUNCE_CYCLES(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   m_level     = 0;
  bit   m_falling   = 1'b1;
  bit   m_fault     = 1'b0;
  bit   m_sticky    = 1'b0;

  function automatic bit therm(input logic [2:0] v);
    return (v == 3'b000) || (v == 3'b001) || (v == 3'b011) || (v == 3'b111);
  endfunction

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, got, exp);
    end
  endtask

  // Reference behaviour: computes the post-edge outputs and queues them.
  task automatic model(input logic [2:0] si, input bit clr, input bit rn);
    exp_t e;
    bit   f;
    if (!rn) begin
      m_level = 0; m_falling = 1'b1; m_fault = 1'b0; m_sticky = 1'b0;
    end else begin
      f        = !therm(si);
      m_sticky = (m_sticky && !clr) || f;
      m_fault  = f;
      if (m_level < N && si[m_level] == 1'b1) begin
        m_level++; m_falling = 1'b0;
      end else if (m_level > 0 && si[m_level-1] == 1'b0) begin
        m_level--; m_falling = 1'b1;
      end
    end
    e.fr     = 3'((1 << (N - m_level)) - 1);
    e.dfr    = (m_level == 0) || (m_falling && m_level < N);
    e.level  = level_t'(m_level);
    e.fault  = m_fault;
    e.sticky = m_sticky;
    sb.push_back(e);
  endtask

  task automatic step(input logic [2:0] si, input bit clr, input bit rn, input string tag);
    exp_t e;
    bus.s = si; bus.clr_fault = clr; reset_n = rn;
    model(si, clr, rn);
    @(posedge clk); #1;
    if (sb.size() == 0) begin
      check({tag, ".sb_empty"}, 8'd1, 8'd0);
    end else begin
      e = sb.pop_front();
      check(tag, {bus.fr, bus.dfr, bus.level, bus.fault, bus.fault_sticky}, e);
    end
  endtask

  task automatic expect_frd(input string tag, input logic [3:0] frd, input level_t lv);
    check(tag, {2'b00, bus.fr, bus.dfr, bus.level}, {2'b00, frd, lv});
  endtask

  task automatic expect_flt(input string tag, input logic [1:0] fs);
    check(tag, {6'd0, bus.fault, bus.fault_sticky}, {6'd0, fs});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    bus.s = '0; bus.clr_fault = 1'b0; reset_n = 1'b0;
    #2;
`ifdef RESERVOIR_DEBOUNCE_EN
    for (int i = 0; i < 2; i++) begin
      bus.s = 3'b000; reset_n = 1'b0; @(posedge clk); #1;
    end
    expect_frd("deb_rst", 4'b1111, 2'd0);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.s = 3'b001; @(posedge clk); #1;
      check("deb_glitch", {6'd0, bus.level}, 8'd0);
    end
    for (int i = 0; i < 3; i++) begin
      bus.s = 3'b000; @(posedge clk); #1;
      check("deb_after_glitch", {6'd0, bus.level}, 8'd0);
    end
    for (int i = 1; i <= 5; i++) begin
      bus.s = 3'b001; @(posedge clk); #1;
      check($sformatf("deb_hold%0d", i), {6'd0, bus.level}, (i == 5) ? 8'd1 : 8'd0);
    end
`else
    // Reset with sensors all wet.
    step(3'b111, 1'b0, 1'b0, "rst0");
    step(3'b111, 1'b0, 1'b0, "rst1");
    expect_frd("rst_out", 4'b1111, 2'd0);
    expect_flt("rst_flt", 2'b00);

    // Rise one level per cycle.
    step(3'b111, 1'b0, 1'b1, "rise1"); expect_frd("rise1_d", 4'b0110, 2'd1);
    step(3'b111, 1'b0, 1'b1, "rise2"); expect_frd("rise2_d", 4'b0010, 2'd2);
    step(3'b111, 1'b0, 1'b1, "rise3"); expect_frd("rise3_d", 4'b0000, 2'd3);

    // Fall with hysteresis on the supplemental valve.
    step(3'b011, 1'b0, 1'b1, "fall1"); expect_frd("fall1_d", 4'b0011, 2'd2);
    step(3'b111, 1'b0, 1'b1, "up1");   expect_frd("up1_d",   4'b0000, 2'd3);
    step(3'b011, 1'b0, 1'b1, "fall2"); expect_frd("fall2_d", 4'b0011, 2'd2);
    step(3'b111, 1'b0, 1'b1, "up2");   expect_frd("up2_d",   4'b0000, 2'd3);

    // Fault flag, sticky hold, clear, and set-beats-clear.
    step(3'b101, 1'b0, 1'b1, "flt1");  expect_flt("flt1_d", 2'b11);
    step(3'b001, 1'b0, 1'b1, "flt2");  expect_flt("flt2_d", 2'b01);
    step(3'b001, 1'b1, 1'b1, "clr");   expect_flt("clr_d",  2'b00);
    step(3'b011, 1'b0, 1'b1, "back2"); expect_frd("back2_d", 4'b0010, 2'd2);
    step(3'b010, 1'b1, 1'b1, "setwin"); expect_flt("setwin_d", 2'b11);

    // Mid-operation reset from L2 falling.
    step(3'b111, 1'b0, 1'b1, "to3");
    step(3'b011, 1'b0, 1'b1, "to2f");  expect_frd("to2f_d", 4'b0011, 2'd2);
    step(3'b011, 1'b1, 1'b0, "midrst"); expect_frd("midrst_d", 4'b1111, 2'd0);
    expect_flt("midrst_flt", 2'b00);

    // Multi-level jump settles one step per cycle.
    step(3'b111, 1'b0, 1'b1, "jump1");
    step(3'b000, 1'b0, 1'b1, "jump2");
    step(3'b000, 1'b0, 1'b1, "jump3"); expect_frd("jump3_d", 4'b1111, 2'd0);

    // Random traffic, mostly valid codes.
    for (int i = 0; i < 80; i++) begin
      logic [2:0] si;
      case ($urandom_range(0, 4))
        0: si = 3'b000;
        1: si = 3'b001;
        2: si = 3'b011;
        3: si = 3'b111;
        default: si = 3'($urandom_range(0, 7));
      endcase
      step(si, ($urandom_range(0, 3) == 0), ($urandom_range(0, 19) != 0), "rand");
    end
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
